// File: rtl/mpsk_pkg.sv
// mpsk_pkg: shared types and helpers for the M-PSK symbol mapper.
// Holds the emit FSM state type, the phase-count helper and bin2gray.
package mpsk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Number of phases for a given symbol width.
    function automatic int nsym(input int bits);
        return 1 << bits;
    endfunction

    // Reflected Gray code; 4 bits covers the widest legal symbol.
    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/mpsk_symbol_mapper_if.sv
// mpsk_symbol_mapper_if: serial bit valid/ready handshake.
// master = bit source (bit_in, bit_valid out), slave = mapper (bit_ready out).
interface mpsk_symbol_mapper_if;

    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (
        output bit_in,
        output bit_valid,
        input  bit_ready
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output bit_ready
    );

endinterface

// File: rtl/mpsk_bit_collector.sv
// mpsk_bit_collector: packs serial bits (MSB first) into a symbol index and
// parks it in a one-deep pending register.
// Ports: clk, rst_n (async, active-low); bit_if (slave handshake);
//   i_consume (emitter takes the pending index this edge);
//   o_pend_full, o_pend_idx (pending symbol).
// Build option: MPSK_GRAY_MAP_EN Gray-codes the index before it is parked.
module mpsk_bit_collector
    import mpsk_pkg::*;
#(
    parameter int BITS_PER_SYM = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mpsk_symbol_mapper_if.slave     bit_if,
    input  logic                    i_consume,
    output logic                    o_pend_full,
    output logic [BITS_PER_SYM-1:0] o_pend_idx
);

    localparam int SW = (BITS_PER_SYM > 1) ? BITS_PER_SYM - 1 : 1;
    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_SYM - 1);

    logic [SW-1:0]           r_shift;
    logic [2:0]              r_cnt;
    logic [BITS_PER_SYM-1:0] r_pend;
    logic                    r_pend_full;

    logic                    w_xfer;
    logic                    w_last;
    logic [BITS_PER_SYM-1:0] w_idx;
    logic [BITS_PER_SYM-1:0] w_map;

    // Ready depends only on the pending slot, never on bit_valid.
    assign bit_if.bit_ready = ~r_pend_full;
    assign w_xfer = bit_if.bit_valid & ~r_pend_full;
    assign w_last = (r_cnt == LAST_BIT);

    // Index as it stands once the incoming bit is shifted in.
    generate
        if (BITS_PER_SYM == 1) begin : g_one
            assign w_idx = bit_if.bit_in;
        end else begin : g_many
            assign w_idx = {r_shift[BITS_PER_SYM-2:0], bit_if.bit_in};
        end
    endgenerate

`ifdef MPSK_GRAY_MAP_EN
    logic [3:0] w_idx4;
    logic [3:0] w_gray4;

    always_comb begin
        w_idx4 = '0;
        w_idx4[BITS_PER_SYM-1:0] = w_idx;
    end

    assign w_gray4 = bin2gray(w_idx4);
    assign w_map   = w_gray4[BITS_PER_SYM-1:0];
`else
    assign w_map = w_idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_shift <= w_idx[SW-1:0];
                if (w_last) begin
                    r_cnt  <= '0;
                    r_pend <= w_map;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
            // A completion wins over a consume so the slot stays full.
            if (w_xfer && w_last) begin
                r_pend_full <= 1'b1;
            end else if (i_consume) begin
                r_pend_full <= 1'b0;
            end
        end
    end

    assign o_pend_full = r_pend_full;
    assign o_pend_idx  = r_pend;

endmodule

// File: rtl/mpsk_symbol_mapper.sv
// mpsk_symbol_mapper: serial bits -> M-PSK symbol -> held phase samples.
// Ports: clk, rst_n (async, active-low); bit_if (slave handshake);
//   i_phase_samples (NSYM signed samples, phase k at [k*SAMPLE_W +: SAMPLE_W]);
//   o_mod_out, o_mod_valid, o_sym_start, o_underrun (registered).
// Build option: MPSK_GRAY_MAP_EN (Gray-coded index, see collector).
module mpsk_symbol_mapper
    import mpsk_pkg::*;
#(
    parameter  int BITS_PER_SYM    = 2,
    parameter  int SAMPLE_W        = 10,
    parameter  int SAMPLES_PER_SYM = 8,
    localparam int NSYM            = nsym(BITS_PER_SYM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mpsk_symbol_mapper_if.slave        bit_if,
    input  logic [NSYM*SAMPLE_W-1:0]   i_phase_samples,
    output logic signed [SAMPLE_W-1:0] o_mod_out,
    output logic                       o_mod_valid,
    output logic                       o_sym_start,
    output logic                       o_underrun
);

    localparam int CNT_W =
        (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
    localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(SAMPLES_PER_SYM - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [BITS_PER_SYM-1:0] r_cur;
    logic [CNT_W-1:0]        r_samp_cnt;
    logic [SAMPLE_W-1:0]     r_mod_out;
    logic                    r_mod_valid;
    logic                    r_sym_start;
    logic                    r_underrun;

    logic [BITS_PER_SYM-1:0] w_cur_nxt;
    logic [CNT_W-1:0]        w_samp_cnt_nxt;
    logic [SAMPLE_W-1:0]     w_mod_out_nxt;
    logic                    w_mod_valid_nxt;
    logic                    w_sym_start_nxt;
    logic                    w_underrun_nxt;

    logic                    w_pend_full;
    logic [BITS_PER_SYM-1:0] w_pend_idx;
    logic [SAMPLE_W-1:0]     w_pend_sample;
    logic [SAMPLE_W-1:0]     w_cur_sample;
    logic                    w_last_samp;
    logic                    w_load;
    logic                    w_stop;
    logic                    w_step;

    mpsk_bit_collector #(
        .BITS_PER_SYM (BITS_PER_SYM)
    ) u_collector (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_if      (bit_if),
        .i_consume   (w_load),
        .o_pend_full (w_pend_full),
        .o_pend_idx  (w_pend_idx)
    );

    assign w_pend_sample =
        i_phase_samples[w_pend_idx*SAMPLE_W +: SAMPLE_W];
    assign w_cur_sample =
        i_phase_samples[r_cur*SAMPLE_W +: SAMPLE_W];

    assign w_last_samp = (r_samp_cnt == LAST_SAMP);

    // Load covers both the idle start and the gapless handover.
    assign w_load = w_pend_full &&
        ((r_state == IDLE) || w_last_samp);
    assign w_stop = (r_state == EMIT) && w_last_samp && !w_pend_full;
    assign w_step = (r_state == EMIT) && !w_last_samp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_pend_full) w_state_nxt = EMIT;
            EMIT: if (w_stop)      w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_cur_nxt       = r_cur;
        w_samp_cnt_nxt  = r_samp_cnt;
        w_mod_out_nxt   = r_mod_out;
        w_mod_valid_nxt = r_mod_valid;
        w_sym_start_nxt = 1'b0;
        w_underrun_nxt  = 1'b0;
        unique case (1'b1)
            w_load: begin
                w_cur_nxt       = w_pend_idx;
                w_samp_cnt_nxt  = '0;
                w_mod_out_nxt   = w_pend_sample;
                w_mod_valid_nxt = 1'b1;
                w_sym_start_nxt = 1'b1;
            end
            w_stop: begin
                w_mod_out_nxt   = '0;
                w_mod_valid_nxt = 1'b0;
                w_underrun_nxt  = 1'b1;
            end
            w_step: begin
                w_samp_cnt_nxt = r_samp_cnt + 1'b1;
                w_mod_out_nxt  = w_cur_sample;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur       <= '0;
            r_samp_cnt  <= '0;
            r_mod_out   <= '0;
            r_mod_valid <= 1'b0;
            r_sym_start <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_cur       <= w_cur_nxt;
            r_samp_cnt  <= w_samp_cnt_nxt;
            r_mod_out   <= w_mod_out_nxt;
            r_mod_valid <= w_mod_valid_nxt;
            r_sym_start <= w_sym_start_nxt;
            r_underrun  <= w_underrun_nxt;
        end
    end

    assign o_mod_out   = $signed(r_mod_out);
    assign o_mod_valid = r_mod_valid;
    assign o_sym_start = r_sym_start;
    assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_mpsk_symbol_mapper.sv
// tb_mpsk_symbol_mapper: directed bench for the M-PSK symbol mapper.
// Drives a QPSK instance (2/10/8) and an 8-PSK instance (3/10/1).
module tb_mpsk_symbol_mapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    mpsk_symbol_mapper_if if1 ();
    mpsk_symbol_mapper_if if2 ();

    logic [39:0]       ps1;
    logic [79:0]       ps2;
    logic signed [9:0] mo1, mo2;
    logic              mv1, ss1, un1;
    logic              mv2, ss2, un2;

    mpsk_symbol_mapper #(
        .BITS_PER_SYM    (2),
        .SAMPLE_W        (10),
        .SAMPLES_PER_SYM (8)
    ) u_dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .bit_if          (if1.slave),
        .i_phase_samples (ps1),
        .o_mod_out       (mo1),
        .o_mod_valid     (mv1),
        .o_sym_start     (ss1),
        .o_underrun      (un1)
    );

    mpsk_symbol_mapper #(
        .BITS_PER_SYM    (3),
        .SAMPLE_W        (10),
        .SAMPLES_PER_SYM (1)
    ) u_dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .bit_if          (if2.slave),
        .i_phase_samples (ps2),
        .o_mod_out       (mo2),
        .o_mod_valid     (mv2),
        .o_sym_start     (ss2),
        .o_underrun      (un2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    typedef struct {
        int rep;
        bit v;
        bit b;
        bit rdy;
        bit mv;
        int out;
        bit st;
        bit un;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int rep, input bit v, input bit b,
                       input bit rdy, input bit mv, input int out,
                       input bit st, input bit un);
        vec_t t;
        t = '{rep: rep, v: v, b: b, rdy: rdy, mv: mv,
              out: out, st: st, un: un};
        vecs.push_back(t);
    endtask

    // Each row: expected outputs now, inputs for the coming edge.
    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                if1.bit_valid = vecs[i].v;
                if1.bit_in    = vecs[i].b;
                chk($sformatf("%s[%0d.%0d] ready", tag, i, r),
                    int'(if1.bit_ready), int'(vecs[i].rdy));
                chk($sformatf("%s[%0d.%0d] valid", tag, i, r),
                    int'(mv1), int'(vecs[i].mv));
                chk($sformatf("%s[%0d.%0d] out", tag, i, r),
                    int'(mo1), vecs[i].out);
                chk($sformatf("%s[%0d.%0d] start", tag, i, r),
                    int'(ss1), int'(vecs[i].st));
                chk($sformatf("%s[%0d.%0d] underrun", tag, i, r),
                    int'(un1), int'(vecs[i].un));
                @(posedge clk);
                #1;
            end
        end
        if1.bit_valid = 1'b0;
        vecs.delete();
    endtask

    int pv1[4] = '{-100, 100, 200, 300};
    bit bp[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int esym[3] = '{300, -100, 200};
    bit b8[3]  = '{1'b1, 1'b1, 1'b0};

    initial begin
        int q[$];
        int bidx, nst, nun, bad, e8;
        bit saw_bp, acc;

        for (int k = 0; k < 4; k++) ps1[k*10 +: 10] = 10'(pv1[k]);
        for (int k = 0; k < 8; k++) ps2[k*10 +: 10] = 10'(16 * k + 3);

        // Reset held with valid asserted.
        rst_n = 1'b0;
        if1.bit_valid = 1'b1;
        if1.bit_in    = 1'b1;
        if2.bit_valid = 1'b1;
        if2.bit_in    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ready", int'(if1.bit_ready), 1);
        chk("rst out", int'(mo1), 0);
        chk("rst valid", int'(mv1), 0);
        chk("rst start", int'(ss1), 0);
        chk("rst underrun", int'(un1), 0);
        chk("rst8 ready", int'(if2.bit_ready), 1);
        chk("rst8 valid", int'(mv2), 0);
        if1.bit_valid = 1'b0;
        if2.bit_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single symbol 1,0 -> phase 2 (200) for 8 clocks.
        add(1, 1, 1, 1, 0, 0,   0, 0);
        add(1, 1, 0, 1, 0, 0,   0, 0);
        add(1, 0, 0, 0, 0, 0,   0, 0);
        add(1, 0, 0, 1, 1, 200, 1, 0);
        add(7, 0, 0, 1, 1, 200, 0, 0);
        add(1, 0, 0, 1, 0, 0,   0, 1);
        add(2, 0, 0, 1, 0, 0,   0, 0);
        run_vecs("single");

        // Continuous 00,01,11 -> -100,100,300 with no gap.
        add(1, 1, 0, 1, 0, 0,    0, 0);
        add(1, 1, 0, 1, 0, 0,    0, 0);
        add(1, 1, 0, 0, 0, 0,    0, 0);
        add(1, 1, 0, 1, 1, -100, 1, 0);
        add(1, 1, 1, 1, 1, -100, 0, 0);
        add(6, 0, 0, 0, 1, -100, 0, 0);
        add(1, 1, 1, 1, 1, 100,  1, 0);
        add(1, 1, 1, 1, 1, 100,  0, 0);
        add(6, 0, 0, 0, 1, 100,  0, 0);
        add(1, 0, 0, 1, 1, 300,  1, 0);
        add(7, 0, 0, 1, 1, 300,  0, 0);
        add(1, 0, 0, 1, 0, 0,    0, 1);
        add(2, 0, 0, 1, 0, 0,    0, 0);
        run_vecs("stream");

        // Backpressure: valid held high across 6 bits.
        bidx = 0; nst = 0; nun = 0; saw_bp = 0;
        for (int c = 0; c < 40; c++) begin
            if (mv1) q.push_back(int'(mo1));
            nst += int'(ss1);
            nun += int'(un1);
            if (bidx < 6) begin
                if1.bit_valid = 1'b1;
                if1.bit_in    = bp[bidx];
                if (!if1.bit_ready) saw_bp = 1;
            end else begin
                if1.bit_valid = 1'b0;
            end
            acc = if1.bit_valid && if1.bit_ready;
            @(posedge clk);
            #1;
            if (acc) bidx++;
        end
        if1.bit_valid = 1'b0;
        chk("bp bits taken", bidx, 6);
        chk("bp ready dropped", int'(saw_bp), 1);
        chk("bp samples", q.size(), 24);
        chk("bp sym_start", nst, 3);
        chk("bp underrun", nun, 1);
        bad = 0;
        for (int s = 0; s < 3; s++)
            for (int j = 0; j < 8; j++)
                if (s * 8 + j >= q.size() || q[s*8+j] != esym[s]) bad++;
        chk("bp order", bad, 0);

        // 8-PSK, one clock per symbol: bits 1,1,0.
`ifdef MPSK_GRAY_MAP_EN
        e8 = 16 * 5 + 3;
`else
        e8 = 16 * 6 + 3;
`endif
        for (int i = 0; i < 3; i++) begin
            if2.bit_valid = 1'b1;
            if2.bit_in    = b8[i];
            chk($sformatf("psk8 ready%0d", i), int'(if2.bit_ready), 1);
            @(posedge clk);
            #1;
        end
        if2.bit_valid = 1'b0;
        chk("psk8 pend ready", int'(if2.bit_ready), 0);
        chk("psk8 pre valid", int'(mv2), 0);
        @(posedge clk);
        #1;
        chk("psk8 valid", int'(mv2), 1);
        chk("psk8 out", int'(mo2), e8);
        chk("psk8 start", int'(ss2), 1);
        @(posedge clk);
        #1;
        chk("psk8 end valid", int'(mv2), 0);
        chk("psk8 end out", int'(mo2), 0);
        chk("psk8 underrun", int'(un2), 1);
        @(posedge clk);
        #1;
        chk("psk8 underrun pulse", int'(un2), 0);

        // Async reset at sample 3 with a partial next symbol queued.
        if1.bit_valid = 1'b1;
        if1.bit_in    = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        if1.bit_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ar first", int'(mo1), 300);
        if1.bit_valid = 1'b1;
        if1.bit_in    = 1'b1;
        @(posedge clk);
        #1;
        if1.bit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ar mid valid", int'(mv1), 1);
        chk("ar mid out", int'(mo1), 300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar valid", int'(mv1), 0);
        chk("ar out", int'(mo1), 0);
        chk("ar start", int'(ss1), 0);
        chk("ar ready", int'(if1.bit_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if1.bit_valid = 1'b1;
        if1.bit_in    = 1'b0;
        @(posedge clk);
        #1;
        if1.bit_in = 1'b1;
        @(posedge clk);
        #1;
        if1.bit_valid = 1'b0;
        chk("ar pend ready", int'(if1.bit_ready), 0);
        @(posedge clk);
        #1;
        chk("ar new valid", int'(mv1), 1);
        chk("ar new out", int'(mo1), 100);
        chk("ar new start", int'(ss1), 1);
        repeat (8) @(posedge clk);
        #1;
        chk("ar new underrun", int'(un1), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
